pawn_move_gen: RTL and testbench

Generates every legal destination square for the pawn on a given source square, one move per handshake. It is the producer-side counterpart of the pawn move checker: the checker judges one proposed move, while this block enumerates the moves for the legal-move highlighter and the check/mate search in game_play. Board encoding is shared with the board validator.

---
 rtl/chess_pkg.sv | 36 +++
 rtl/pawn_target_eval.sv | 75 +++++++
 rtl/pawn_move_gen.sv | 121 ++++++++++++
 tb/tb_pawn_move_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: board encoding shared with the board validator and the pawn
// move checker, and the state type of the pawn move generator.
//   board_t     : 8x8 board of 4-bit square codes, indexed [y][x]
//   pmg_state_t : pawn_move_gen enumeration states
package chess_pkg;

  localparam logic [3:0] EMPTY      = 4'd15;
  localparam logic [3:0] WHITE_PAWN = 4'd5;
  localparam logic [3:0] BLACK_PAWN = 4'd11;

  // White pieces occupy 0..WHITE_MAX, black pieces BLACK_MIN..BLACK_MAX.
  // Codes 12..14 are unknown and belong to neither side.
  localparam logic [3:0] WHITE_MAX  = 4'd5;
  localparam logic [3:0] BLACK_MIN  = 4'd6;
  localparam logic [3:0] BLACK_MAX  = 4'd11;

  typedef logic [7:0][7:0][3:0] board_t;

  typedef enum logic [2:0] {
    IDLE,
    PUSH1,
    PUSH2,
    CAP_L,
    CAP_R,
    DONE
  } pmg_state_t;

  function automatic logic is_white_piece(input logic [3:0] code);
    return code <= WHITE_MAX;
  endfunction

  function automatic logic is_black_piece(input logic [3:0] code);
    return (code >= BLACK_MIN) && (code <= BLACK_MAX);
  endfunction

endpackage

// File: rtl/pawn_target_eval.sv
// pawn_target_eval: combinational evaluation of the candidate move for the
// current enumeration state.
//   state        : candidate being evaluated (PUSH1/PUSH2/CAP_L/CAP_R)
//   src_x/src_y  : latched source square
//   white        : 1 when the source pawn is white
//   board        : board, [y][x]
//   legal        : the candidate move is legal
//   dst_x/dst_y  : candidate destination (meaningful only when legal)
//   capture      : candidate is a diagonal capture
module pawn_target_eval
  import chess_pkg::*;
#(
  parameter bit ENABLE_DOUBLE_PUSH = 1'b1
) (
  input  pmg_state_t state,
  input  logic [2:0] src_x,
  input  logic [2:0] src_y,
  input  logic       white,
  input  board_t     board,
  output logic       legal,
  output logic [2:0] dst_x,
  output logic [2:0] dst_y,
  output logic       capture
);

  logic       fwd_ok;
  logic       on_start;
  logic [2:0] y1;
  logic [2:0] y2;

  // A pawn on its last rank has no forward square; y1/y2 may wrap in that
  // case, so every board read below is gated by fwd_ok first.
  assign fwd_ok   = white ? (src_y != 3'd0) : (src_y != 3'd7);
  assign on_start = white ? (src_y == 3'd6) : (src_y == 3'd1);
  assign y1       = white ? (src_y - 3'd1) : (src_y + 3'd1);
  assign y2       = white ? (src_y - 3'd2) : (src_y + 3'd2);

  function automatic logic is_opponent(input logic [3:0] code, input logic mover_white);
    return mover_white ? is_black_piece(code) : is_white_piece(code);
  endfunction

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    legal   = 1'b0;
    dst_x   = src_x;
    dst_y   = y1;
    capture = 1'b0;
    unique case (state)
      PUSH1: begin
        if (fwd_ok) legal = (board[y1][src_x] == EMPTY);
      end
      PUSH2: begin
        dst_y = y2;
        // The start rank guarantees both squares are on the board.
        if (ENABLE_DOUBLE_PUSH && on_start)
          legal = (board[y1][src_x] == EMPTY) && (board[y2][src_x] == EMPTY);
      end
      CAP_L: begin
        dst_x   = src_x - 3'd1;
        capture = 1'b1;
        if (fwd_ok && (src_x != 3'd0))
          legal = is_opponent(board[y1][src_x - 3'd1], white);
      end
      CAP_R: begin
        dst_x   = src_x + 3'd1;
        capture = 1'b1;
        if (fwd_ok && (src_x != 3'd7))
          legal = is_opponent(board[y1][src_x + 3'd1], white);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pawn_move_gen.sv
// pawn_move_gen: enumerates the legal destinations of the pawn on a source
// square, one move per valid/ready handshake, then pulses done.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : request, accepted only in IDLE
//   src_x/src_y        : source square, captured on an accepted start
//   board_in           : board [y][x], stable while busy
//   move_valid/ready   : move handshake
//   dst_x/dst_y        : destination of the presented move
//   move_capture       : presented move is a diagonal capture
//   busy               : enumeration in progress (through DONE)
//   done               : one-cycle end-of-enumeration pulse
//   move_count         : moves handshaken, valid with done
//   bad_src            : source square held no pawn, valid with done
module pawn_move_gen
  import chess_pkg::*;
#(
  parameter bit ENABLE_DOUBLE_PUSH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] src_x,
  input  logic [2:0] src_y,
  input  board_t     board_in,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [2:0] dst_x,
  output logic [2:0] dst_y,
  output logic       move_capture,
  output logic       busy,
  output logic       done,
  output logic [2:0] move_count,
  output logic       bad_src
);

  pmg_state_t state, state_n;
  logic [2:0] src_x_q, src_y_q;
  logic       white_q;
  logic [2:0] count_q;
  logic       bad_q;

  logic       legal;
  logic [2:0] ev_x, ev_y;
  logic       ev_cap;
  logic [3:0] src_code;
  logic       accept;
  logic       fire;

  assign src_code = board_in[src_y][src_x];
  assign accept   = (state == IDLE) && start;
  assign fire     = move_valid && move_ready;

  pawn_target_eval #(
    .ENABLE_DOUBLE_PUSH(ENABLE_DOUBLE_PUSH)
  ) u_eval (
    .state  (state),
    .src_x  (src_x_q),
    .src_y  (src_y_q),
    .white  (white_q),
    .board  (board_in),
    .legal  (legal),
    .dst_x  (ev_x),
    .dst_y  (ev_y),
    .capture(ev_cap)
  );

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears them immediately without waiting for a clock edge.
  assign move_valid   = legal;
  assign dst_x        = legal ? ev_x : 3'd0;
  assign dst_y        = legal ? ev_y : 3'd0;
  assign move_capture = legal && ev_cap;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign move_count   = done ? count_q : 3'd0;
  assign bad_src      = done && bad_q;

  // NOTE: all control registers are reset; the board is an input, so there
  // is no storage here that could be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      src_x_q <= 3'd0;
      src_y_q <= 3'd0;
      white_q <= 1'b0;
      count_q <= 3'd0;
      bad_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        src_x_q <= src_x;
        src_y_q <= src_y;
        white_q <= (src_code == WHITE_PAWN);
        count_q <= 3'd0;
        bad_q   <= (src_code != WHITE_PAWN) && (src_code != BLACK_PAWN);
      end else if (fire) begin
        count_q <= count_q + 3'd1;
      end
    end
  end

  // A candidate state holds only while its move is presented and refused.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = ((src_code == WHITE_PAWN) || (src_code == BLACK_PAWN)) ? PUSH1 : DONE;
      end
      PUSH1: if (!legal || move_ready) state_n = PUSH2;
      PUSH2: if (!legal || move_ready) state_n = CAP_L;
      CAP_L: if (!legal || move_ready) state_n = CAP_R;
      CAP_R: if (!legal || move_ready) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pawn_move_gen.sv
// tb_pawn_move_gen: directed scoreboard bench for pawn_move_gen. Stimulus
// pushes hand-computed moves and done records into queues; a monitor pops
// and compares on every handshake and every done pulse.
module tb_pawn_move_gen;
  import chess_pkg::*;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       cap;
  } move_t;

  typedef struct packed {
    logic [2:0] cnt;
    logic       bad;
  } done_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] src_x, src_y;
  board_t     board;
  logic       move_valid, move_ready;
  logic [2:0] dst_x, dst_y;
  logic       move_capture, busy, done, bad_src;
  logic [2:0] move_count;

  int checks = 0;
  int errors = 0;
  move_t move_q[$];
  done_t done_q[$];

  pawn_move_gen #(.ENABLE_DOUBLE_PUSH(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .src_x       (src_x),
    .src_y       (src_y),
    .board_in    (board),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .dst_x       (dst_x),
    .dst_y       (dst_y),
    .move_capture(move_capture),
    .busy        (busy),
    .done        (done),
    .move_count  (move_count),
    .bad_src     (bad_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (move_valid && move_ready) begin
        if (move_q.size() == 0) begin
          check("extra_move", move_valid, 0);
        end else begin
          move_t e;
          e = move_q.pop_front();
          check("dst_x", dst_x, e.x);
          check("dst_y", dst_y, e.y);
          check("move_capture", move_capture, e.cap);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("extra_done", done, 0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("move_count", move_count, d.cnt);
          check("bad_src", bad_src, d.bad);
        end
      end
    end
  end

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board[y][x] = EMPTY;
  endtask

  task automatic init_board();
    logic [3:0] back [8];
    back = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd0, 4'd2, 4'd1, 4'd3};
    clear_board();
    for (int x = 0; x < 8; x++) begin
      board[0][x] = back[x] + 4'd6;
      board[1][x] = BLACK_PAWN;
      board[6][x] = WHITE_PAWN;
      board[7][x] = back[x];
    end
  endtask

  task automatic exp_move(input logic [2:0] x, input logic [2:0] y, input logic cap);
    move_q.push_back('{x: x, y: y, cap: cap});
  endtask

  // Issues one request; stall > 0 holds move_ready low for the first stall
  // cycles of PUSH1 (white pawn assumed for the stability check).
  task automatic run_gen(input string tag, input logic [2:0] sx, input logic [2:0] sy,
                         input int stall, input int exp_lat,
                         input logic [2:0] exp_cnt, input logic exp_bad);
    int n;
    done_q.push_back('{cnt: exp_cnt, bad: exp_bad});
    src_x      = sx;
    src_y      = sy;
    move_ready = (stall == 0);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 1;
    while (!done && n < 40) begin
      if (n <= stall) begin
        check({tag, "_stall_valid"}, move_valid, 1);
        check({tag, "_stall_x"}, dst_x, sx);
        check({tag, "_stall_y"}, dst_y, sy - 3'd1);
      end
      if (n == stall + 1) move_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    @(posedge clk); #1;
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    src_x      = 3'd0;
    src_y      = 3'd0;
    move_ready = 1'b1;
    init_board();
    #12;
    check("rst_valid", move_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", move_count, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: white opening pawn, single and double push.
    exp_move(3'd4, 3'd5, 1'b0);
    exp_move(3'd4, 3'd4, 1'b0);
    run_gen("t1", 3'd4, 3'd6, 0, 5, 3'd2, 1'b0);

    // 2: black edge pawn, both pushes and a right capture of a white bishop.
    clear_board();
    board[1][0] = BLACK_PAWN;
    board[2][1] = 4'd2;
    exp_move(3'd0, 3'd2, 1'b0);
    exp_move(3'd0, 3'd3, 1'b0);
    exp_move(3'd1, 3'd2, 1'b1);
    run_gen("t2", 3'd0, 3'd1, 0, 5, 3'd3, 1'b0);

    // 3: blocked pawn, double push suppressed too.
    init_board();
    board[5][3] = 4'd7;
    run_gen("t3", 3'd3, 3'd6, 0, 5, 3'd0, 1'b0);

    // 4: backpressure for 3 cycles during PUSH1.
    init_board();
    exp_move(3'd4, 3'd5, 1'b0);
    exp_move(3'd4, 3'd4, 1'b0);
    run_gen("t4", 3'd4, 3'd6, 3, 8, 3'd2, 1'b0);

    // 5: empty source square.
    run_gen("t5", 3'd2, 3'd2, 0, 1, 3'd0, 1'b1);

    // 6: right-edge white pawn, left capture, not on start rank.
    clear_board();
    board[3][7] = WHITE_PAWN;
    board[2][6] = 4'd8;
    exp_move(3'd7, 3'd2, 1'b0);
    exp_move(3'd6, 3'd2, 1'b1);
    run_gen("t6", 3'd7, 3'd3, 0, 5, 3'd2, 1'b0);

    // 7: white pawn on the last rank generates nothing.
    clear_board();
    board[0][2] = WHITE_PAWN;
    board[1][1] = 4'd9;
    run_gen("t7", 3'd2, 3'd0, 0, 5, 3'd0, 1'b0);

    // 8: own-colour and unknown codes on the diagonals are not captured.
    clear_board();
    board[4][3] = BLACK_PAWN;
    board[5][2] = 4'd8;
    board[5][4] = 4'd13;
    exp_move(3'd3, 3'd5, 1'b0);
    run_gen("t8", 3'd3, 3'd4, 0, 5, 3'd1, 1'b0);

    // 9: reset while stalled in PUSH2 aborts without done.
    init_board();
    exp_move(3'd4, 3'd5, 1'b0);
    src_x      = 3'd4;
    src_y      = 3'd6;
    move_ready = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    move_ready = 1'b0;
    check("t9_push2_valid", move_valid, 1);
    check("t9_push2_y", dst_y, 4);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t9_rst_valid", move_valid, 0);
    check("t9_rst_dst", {dst_x, dst_y}, 0);
    check("t9_rst_cap", move_capture, 0);
    check("t9_rst_busy", busy, 0);
    check("t9_rst_done", done, 0);
    check("t9_rst_count", move_count, 0);
    check("t9_rst_bad", bad_src, 0);
    check("t9_moves_flushed", move_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    move_ready = 1'b1;
    @(posedge clk); #1;
    exp_move(3'd4, 3'd5, 1'b0);
    exp_move(3'd4, 3'd4, 1'b0);
    run_gen("t9_rerun", 3'd4, 3'd6, 0, 5, 3'd2, 1'b0);

    repeat (3) @(posedge clk);
    check("moves_left", move_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
